// File: rtl/line_pkg.sv
`default_nettype none
// ============================================================================
//  Module : line_pkg
//  Shared constants, collision-FSM state type and x-to-bit helper for line_scanout.
//  Rev    : 1.0
// ============================================================================
package line_pkg;

    localparam int LINE_W    = 640;
    localparam int BAND_TOP  = 400;
    localparam int BAND_H    = 8;
    localparam int PLAYER_X  = 64;
    localparam int PLAYER_W  = 16;
    localparam int ROW_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } chk_state_t;

    // Screen column x lives at bit (width-1-x): the newest terrain bit is the rightmost pixel.
    function automatic int unsigned x_to_bit(input int unsigned x, input int unsigned w = LINE_W);
        return w - 1 - x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_shift_out.sv
`default_nettype none
// ============================================================================
//  Module : line_shift_out
//  Per-row terrain shift register and ground-band gating that drives pixel_o.
//  Rev    : 1.0
// ============================================================================
module line_shift_out
    import line_pkg::*;
#(
    parameter int LINE_W   = line_pkg::LINE_W,
    parameter int BAND_TOP = line_pkg::BAND_TOP,
    parameter int BAND_H   = line_pkg::BAND_H
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [LINE_W-1:0]    load_data_i,
    input  logic [ROW_CNT_W-1:0] row_cnt_i,
    input  logic                 pix_en_i,
    input  logic                 de_i,
    output logic                 pixel_o
);

    logic [LINE_W-1:0] r_sr;
    logic              r_in_band;
    logic              r_pixel;
    logic              w_in_band_nxt;

    assign w_in_band_nxt = (row_cnt_i >= ROW_CNT_W'(BAND_TOP)) &&
                           (row_cnt_i <  ROW_CNT_W'(BAND_TOP + BAND_H));

    // The shifter refills with zeros, so an over-long row draws nothing.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sr      <= '0;
            r_in_band <= 1'b0;
            r_pixel   <= 1'b0;
        end else begin
            if (load_i) begin
                r_sr      <= load_data_i;
                r_in_band <= w_in_band_nxt;
            end else if (pix_en_i && de_i) begin
                r_sr <= {r_sr[LINE_W-2:0], 1'b0};
            end
            if (pix_en_i) begin
                r_pixel <= de_i & r_in_band & r_sr[LINE_W-1];
            end
        end
    end

    assign pixel_o = r_pixel;

endmodule
`default_nettype wire

// File: rtl/line_scanout.sv
`default_nettype none
// ============================================================================
//  Module : line_scanout
//  Freezes the terrain line each frame, serialises the ground band and runs
//  the under-player gap check.
//  Rev    : 1.0
// ============================================================================
module line_scanout
    import line_pkg::*;
#(
    parameter int LINE_W   = line_pkg::LINE_W,
    parameter int BAND_TOP = line_pkg::BAND_TOP,
    parameter int BAND_H   = line_pkg::BAND_H,
    parameter int PLAYER_X = line_pkg::PLAYER_X,
    parameter int PLAYER_W = line_pkg::PLAYER_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [LINE_W-1:0] line_i,
    input  logic              frame_start_i,
    input  logic              row_start_i,
    input  logic              pix_en_i,
    input  logic              de_i,
    input  logic              on_ground_i,
    input  logic              fall_clr_i,
    output logic              pixel_o,
    output logic              fall_o,
    output logic              check_busy_o
);

    localparam int IDX_W = (PLAYER_W > 1) ? $clog2(PLAYER_W) : 1;
    localparam int BIT_W = $clog2(LINE_W);

    logic [LINE_W-1:0]    r_snap;
    logic [LINE_W-1:0]    w_snap_cur;
    logic [ROW_CNT_W-1:0] r_row_cnt;
    logic [ROW_CNT_W-1:0] w_row_cnt_cur;
    logic [ROW_CNT_W-1:0] w_row_cnt_nxt;

    chk_state_t           r_state;
    chk_state_t           w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 r_any;
    logic                 w_any_nxt;
    logic                 r_fall;
    logic                 w_fall_nxt;
    logic [BIT_W-1:0]     w_chk_bit;

    // A frame start in the same cycle as a row start must be seen by that row.
    assign w_snap_cur    = frame_start_i ? line_i : r_snap;
    assign w_row_cnt_cur = frame_start_i ? '0 : r_row_cnt;
    assign w_row_cnt_nxt = !row_start_i   ? w_row_cnt_cur :
                           (&w_row_cnt_cur) ? w_row_cnt_cur :
                           w_row_cnt_cur + ROW_CNT_W'(1);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_snap    <= '1;
            r_row_cnt <= '0;
        end else begin
            r_snap    <= w_snap_cur;
            r_row_cnt <= w_row_cnt_nxt;
        end
    end

    line_shift_out #(
        .LINE_W   (LINE_W),
        .BAND_TOP (BAND_TOP),
        .BAND_H   (BAND_H)
    ) u_shift (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_i      (row_start_i),
        .load_data_i (w_snap_cur),
        .row_cnt_i   (w_row_cnt_cur),
        .pix_en_i    (pix_en_i),
        .de_i        (de_i),
        .pixel_o     (pixel_o)
    );

    assign w_chk_bit = BIT_W'(x_to_bit(PLAYER_X + int'(r_idx), LINE_W));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_any   <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_any   <= w_any_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Clear is applied first so a same-cycle set from DONE overrides it.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_any_nxt   = r_any;
        w_fall_nxt  = r_fall & ~fall_clr_i;
        case (r_state)
            IDLE: begin
                if (frame_start_i && on_ground_i) begin
                    w_state_nxt = CHECK;
                    w_idx_nxt   = '0;
                    w_any_nxt   = 1'b0;
                end
            end
            CHECK: begin
                if (frame_start_i) begin
                    w_idx_nxt = '0;
                    w_any_nxt = 1'b0;
                end else begin
                    w_any_nxt = r_any | r_snap[w_chk_bit];
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == IDX_W'(PLAYER_W - 1)) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!r_any) begin
                    w_fall_nxt = 1'b1;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign fall_o       = r_fall;
    assign check_busy_o = (r_state == CHECK);

endmodule
`default_nettype wire
